ctrl_mc_gen2: RTL
=================

Name: ctrl_mc_gen2

Overview:
Second-generation multi-cycle CPU control FSM. It sequences START0, START1, FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and decodes control signals for the datapath: PC, register file, ALU and data memory. Beyond the first generation, it adds:
- parametrised field widths;
- full LOD/STR/BRA/BRR/BNE support;
- a data-memory ready handshake with a stall timeout;
- a synthesizable HALT state that replaces the simulation stop.

Parameters:
OP_W, 4, opcode field width (Instr[31:28]).
MM_W, 4, addressing-mode/condition field width (Instr[27:24]).
STAT_W, 4, status flag width; must equal MM_W.
MEM_HS, 1, 1 = MEM state waits for MEM_RDY; 0 = MEM_RDY ignored, MEM lasts one cycle.
STALL_MAX, 15, max MEM wait cycles before abort (>=1).

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  asynchronous active-low reset
OPCODE  in  OP_W  instruction opcode, stable DECODE..WRITEBACK
MM  in  MM_W  addressing mode (ALU) or condition mask (BNE)
STAT  in  STAT_W  ALU status flags
MEM_RDY  in  1  data memory completes access this cycle
RF_WE  out  1  register file write enable
ALU_OP  out  2  00 reg-reg, 01 immediate, 10 address add
WB_SEL  out  1  0 ALU result, 1 memory data
RD_SEL  out  1  1 selects alternate read-register field
PC_SEL  out  1  0 PC+1, 1 branch target
BR_SEL  out  1  0 absolute target, 1 PC-relative target
PC_WRITE  out  1  PC load enable
PC_RST  out  1  PC reset
MEM_REQ  out  1  data memory access request
MEM_WE  out  1  data memory write (valid with MEM_REQ)
MEM_ERR  out  1  sticky: a MEM stall timed out
HALTED  out  1  FSM in HALT

Behaviour:
- Opcodes: NOOP 0, LOD 1, STR 2, BRA 4, BRR 5, BNE 6, ALU 8, HLT 15, zero-extended to OP_W. Immediate mode: MM == 8. Undefined opcodes execute as NOOP.
- State register only (3 bits), plus stall counter (clog2(STALL_MAX+1) bits) and MEM_ERR flag. RST_F low asynchronously forces state START0, counter 0, MEM_ERR 0. All other outputs are combinational from state, OPCODE, MM, STAT, MEM_RDY, with zero cycle latency. Every output defaults to 0 unless listed below.
- Transitions:
  - START0 -> START1 -> FETCH -> DECODE.
  - DECODE -> HALT if OPCODE == HLT, else -> EXECUTE.
  - EXECUTE -> MEM -> WRITEBACK -> FETCH.
  - HALT is absorbing until reset.
- START0, START1: PC_RST=1.
- FETCH: PC_WRITE=1, PC_SEL=0 (PC <= PC+1).
- DECODE: RD_SEL=1 for (ALU and MM==8) or STR.
- EXECUTE, ALU_OP:
  - ALU with MM==8 -> 01; ALU otherwise -> 00.
  - LOD/STR -> 10; all other opcodes -> 00.
- EXECUTE, branches:
  - BRA: PC_WRITE=1, PC_SEL=1, BR_SEL=0.
  - BRR: PC_WRITE=1, PC_SEL=1, BR_SEL=1.
  - BNE: BR_SEL=1 always. If (STAT & MM)==0, branch is taken: PC_WRITE=1, PC_SEL=1. Otherwise PC_WRITE=0.
- MEM, LOD/STR:
  - MEM_REQ=1; MEM_WE=1 for STR only; ALU_OP held at 10.
  - With MEM_HS=1, the FSM stays in MEM while MEM_RDY=0, incrementing the counter each stall cycle.
  - MEM_RDY=1 -> WRITEBACK; counter cleared.
  - Counter reaching STALL_MAX with MEM_RDY still 0: MEM_ERR set (sticky until reset), counter cleared, next state FETCH. WRITEBACK is skipped, so no RF_WE.
  - MEM_RDY=1 in the same cycle as timeout: the access completes and no error is raised.
  - Other opcodes pass through MEM in one cycle with no request.
- WRITEBACK:
  - ALU: RF_WE=1, WB_SEL=0, ALU_OP held at the EXECUTE value.
  - LOD: RF_WE=1, WB_SEL=1.
  - STR, branches, NOOP: no write.
- HALT: HALTED=1, every other output 0 (PC frozen, no memory or register-file activity).
- Reset mid-instruction, including during a MEM stall, abandons the instruction immediately. MEM_REQ drops asynchronously with reset.

Test Plan:
1. Reset release, OPCODE=0 -> PC_RST=1 for 2 cycles, then FETCH with PC_WRITE=1. Period 5 cycles (FETCH..WRITEBACK), RF_WE never 1.
2. ALU, MM=8 -> RD_SEL=1 in DECODE, ALU_OP=01 in EXECUTE and WRITEBACK, RF_WE=1 only in WRITEBACK. Repeat with MM=0 -> ALU_OP=00, RD_SEL=0.
3. LOD, MEM_RDY low 3 cycles then high -> MEM_REQ=1 for 4 cycles with MEM_WE=0. WRITEBACK then gives RF_WE=1, WB_SEL=1. STR with the same stimulus gives MEM_WE=1 and no RF_WE.
4. BNE with MM=4'b0001: STAT=0000 -> PC_SEL=1, BR_SEL=1, PC_WRITE=1 in EXECUTE. STAT=0001 -> PC_WRITE=0 in EXECUTE.
5. STR, MEM_RDY held 0, STALL_MAX=15 -> after 15 stall cycles MEM_ERR=1 and the next state is FETCH. MEM_ERR stays 1 through later instructions until RST_F pulses low.
6. HLT in DECODE -> HALTED=1 and all other outputs 0 for 20 cycles. Asserting RST_F low mid-HALT returns to START0 asynchronously, with PC_RST=1 in the same time step.

Source files
------------

// File: rtl/ctrl_mc_gen2.sv
// rtl/ctrl_mc_gen2.sv - multi-cycle CPU control FSM with memory handshake, stall timeout and halt
module ctrl_mc_gen2 #(
    parameter int OP_W      = 4,
    parameter int MM_W      = 4,
    parameter int STAT_W    = 4,
    parameter int MEM_HS    = 1,
    parameter int STALL_MAX = 15
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic [OP_W-1:0]   OPCODE,
    input  logic [MM_W-1:0]   MM,
    input  logic [STAT_W-1:0] STAT,
    input  logic              MEM_RDY,
    output logic              RF_WE,
    output logic [1:0]        ALU_OP,
    output logic              WB_SEL,
    output logic              RD_SEL,
    output logic              PC_SEL,
    output logic              BR_SEL,
    output logic              PC_WRITE,
    output logic              PC_RST,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic              MEM_ERR,
    output logic              HALTED
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);

    localparam logic [2:0] S_START0 = 3'd0;
    localparam logic [2:0] S_START1 = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEM    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);
    localparam logic [MM_W-1:0] MM_IMM = MM_W'(8);

    localparam logic             HS_ON    = (MEM_HS != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_MAX - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_set;
    logic             w_is_mem;
    logic             w_is_alu_imm;
    logic             w_bne_taken;

    assign w_is_mem     = (OPCODE == OP_LOD) || (OPCODE == OP_STR);
    assign w_is_alu_imm = (OPCODE == OP_ALU) && (MM == MM_IMM);
    assign w_bne_taken  = ((STAT & MM) == '0);
    assign MEM_ERR      = r_err;

    // Next-state and stall-counter logic; a timed-out access aborts straight to FETCH.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            S_START0: w_state_nxt = S_START1;
            S_START1: w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = (OPCODE == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   w_state_nxt = S_MEM;
            S_MEM: begin
                if (w_is_mem && HS_ON) begin
                    if (MEM_RDY) begin
                        w_state_nxt = S_WB;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = '0;
                        w_err_set   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB:     w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_HALT;
        endcase
    end

    // State, stall counter and sticky error flag registers.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_state <= S_START0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Datapath control decode from state and current instruction fields.
    always_comb begin
        RF_WE    = 1'b0;
        ALU_OP   = 2'b00;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        PC_SEL   = 1'b0;
        BR_SEL   = 1'b0;
        PC_WRITE = 1'b0;
        PC_RST   = 1'b0;
        MEM_REQ  = 1'b0;
        MEM_WE   = 1'b0;
        HALTED   = 1'b0;
        case (r_state)
            S_START0, S_START1: PC_RST = 1'b1;
            S_FETCH:  PC_WRITE = 1'b1;
            S_DECODE: RD_SEL = w_is_alu_imm || (OPCODE == OP_STR);
            S_EXEC: begin
                if (w_is_alu_imm) begin
                    ALU_OP = 2'b01;
                end else if (w_is_mem) begin
                    ALU_OP = 2'b10;
                end
                case (OPCODE)
                    OP_BRA: begin
                        PC_WRITE = 1'b1;
                        PC_SEL   = 1'b1;
                    end
                    OP_BRR: begin
                        PC_WRITE = 1'b1;
                        PC_SEL   = 1'b1;
                        BR_SEL   = 1'b1;
                    end
                    OP_BNE: begin
                        BR_SEL   = 1'b1;
                        PC_WRITE = w_bne_taken;
                        PC_SEL   = w_bne_taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (w_is_mem) begin
                    MEM_REQ = 1'b1;
                    MEM_WE  = (OPCODE == OP_STR);
                    ALU_OP  = 2'b10;
                end
            end
            S_WB: begin
                if (OPCODE == OP_ALU) begin
                    RF_WE  = 1'b1;
                    ALU_OP = w_is_alu_imm ? 2'b01 : 2'b00;
                end else if (OPCODE == OP_LOD) begin
                    RF_WE  = 1'b1;
                    WB_SEL = 1'b1;
                end
            end
            default: HALTED = 1'b1;
        endcase
    end

endmodule
